// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: request/response bundle between the execute stage and the multiply unit
interface seq_multiplier_if #(parameter int XLEN = 32);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            ready_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  modport master (output start_i, funct3_i, rs1_i, rs2_i, input ready_o, busy_o, valid_o, result_o);
  modport slave (input start_i, funct3_i, rs1_i, rs2_i, output ready_o, busy_o, valid_o, result_o);
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add RV32M MUL/MULH/MULHSU/MULHU unit, one iteration per cycle.
// Define MUL_ZERO_SKIP_EN to finish immediately when either operand is zero.
module seq_multiplier #(
  parameter int XLEN = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  seq_multiplier_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] prod_q, prod_d, fin;
  logic [XLEN-1:0]   mcand_q, mcand_d, result_q, result_d;
  logic              neg_q, neg_d, lo_q, lo_d, s1, s2;
  logic [XLEN:0]     sum;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      lo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      lo_q     <= lo_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    lo_d     = lo_q;
    result_d = result_q;
    fin      = '0;
    s1       = (bus.funct3_i[1] ^ bus.funct3_i[0]) & bus.rs1_i[XLEN-1];
    s2       = (bus.funct3_i[1:0] == 2'b01) & bus.rs2_i[XLEN-1];
    sum      = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, prod_q[0] ? mcand_q : '0};
    case (state_q)
      IDLE: if (bus.start_i && !bus.funct3_i[2]) begin
        state_d = BUSY;
        cnt_d   = '0;
        mcand_d = s1 ? -bus.rs1_i : bus.rs1_i;
        prod_d  = {{XLEN{1'b0}}, s2 ? -bus.rs2_i : bus.rs2_i};
        neg_d   = s1 ^ s2;
        lo_d    = bus.funct3_i[1:0] == 2'b00;
`ifdef MUL_ZERO_SKIP_EN
        if (bus.rs1_i == '0 || bus.rs2_i == '0) begin
          state_d  = DONE;
          result_d = '0;
        end
`endif
      end
      BUSY: begin
        // carry-out of the add becomes the new MSB as the product shifts right
        prod_d = {sum, prod_q[XLEN-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          state_d  = DONE;
          fin      = neg_q ? -prod_d : prod_d;
          result_d = lo_q ? fin[XLEN-1:0] : fin[2*XLEN-1:XLEN];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.ready_o  = state_q == IDLE;
  assign bus.busy_o   = state_q != IDLE;
  assign bus.valid_o  = state_q == DONE;
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed vectors against an arithmetic reference model with cycle-level output checking
module tb_seq_multiplier;
  localparam int XLEN = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int checks = 0;
  int fails = 0;
  int m_rem = 0;
  logic m_valid = 1'b0;
  logic m_skip;
  logic [XLEN-1:0] m_res = '0;
  logic [XLEN-1:0] m_next = '0;

  seq_multiplier_if #(.XLEN(XLEN)) bus ();
  seq_multiplier #(.XLEN(XLEN)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] ref_mul(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic signed [2*XLEN+1:0] sa, sb, p;
    sa = (f[1:0] == 2'b01 || f[1:0] == 2'b10) ? {{(XLEN+2){a[XLEN-1]}}, a} : {{(XLEN+2){1'b0}}, a};
    sb = (f[1:0] == 2'b01) ? {{(XLEN+2){b[XLEN-1]}}, b} : {{(XLEN+2){1'b0}}, b};
    p = sa * sb;
    return (f[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

`ifdef MUL_ZERO_SKIP_EN
  assign m_skip = bus.rs1_i == '0 || bus.rs2_i == '0;
`else
  assign m_skip = 1'b0;
`endif

  // Reference: an accepted op produces its result XLEN edges later (or at once when skipped)
  always @(posedge clk) begin
    if (rst) begin
      m_rem   <= 0;
      m_valid <= 1'b0;
      m_res   <= '0;
    end else if (m_rem == 0 && !m_valid && bus.start_i && !bus.funct3_i[2]) begin
      if (m_skip) begin
        m_valid <= 1'b1;
        m_res   <= '0;
      end else begin
        m_rem  <= XLEN;
        m_next <= ref_mul(bus.funct3_i, bus.rs1_i, bus.rs2_i);
      end
    end else begin
      m_valid <= m_rem == 1;
      if (m_rem == 1) m_res <= m_next;
      if (m_rem > 0) m_rem <= m_rem - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 64'(bus.valid_o), 64'(m_valid));
      check("ready", 64'(bus.ready_o), 64'(m_rem == 0 && !m_valid));
      check("busy", 64'(bus.busy_o), 64'(m_rem != 0 || m_valid));
      if (m_valid) check("result", 64'(bus.result_o), 64'(m_res));
    end
  end

  task automatic run_op(input string nm, input logic [2:0] f, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int disturb);
    int cyc;
    int lat;
    lat = XLEN + 1;
`ifdef MUL_ZERO_SKIP_EN
    if (a == '0 || b == '0) lat = 1;
`endif
    check({nm, "_model"}, 64'(ref_mul(f, a, b)), 64'(exp));
    bus.start_i  = 1'b1;
    bus.funct3_i = f;
    bus.rs1_i    = a;
    bus.rs2_i    = b;
    @(negedge clk);
    cyc = 1;
    bus.start_i  = 1'b0;
    bus.rs1_i    = $urandom;
    bus.rs2_i    = $urandom;
    bus.funct3_i = 3'($urandom_range(0, 7));
    while (!bus.valid_o && cyc < 100) begin
      bus.start_i = cyc == disturb || cyc == disturb + 1;
      if (cyc == disturb) begin
        bus.funct3_i = 3'b100;
        bus.rs1_i    = $urandom;
        bus.rs2_i    = $urandom;
      end else if (cyc == disturb + 1) bus.funct3_i = 3'b000;
      @(negedge clk);
      cyc++;
    end
    bus.start_i = 1'b0;
    check({nm, "_latency"}, 64'(cyc), 64'(lat));
    check({nm, "_result"}, 64'(bus.result_o), 64'(exp));
    @(negedge clk);
    check({nm, "_pulse"}, 64'(bus.valid_o), 64'd0);
    check({nm, "_ready"}, 64'(bus.ready_o), 64'd1);
  endtask

  initial begin
    int pulses;
    bus.start_i  = 1'b0;
    bus.funct3_i = 3'b000;
    bus.rs1_i    = '0;
    bus.rs2_i    = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.ready_o), 64'd1);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_result", 64'(bus.result_o), 64'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    run_op("mul_7x6", 3'b000, 32'd7, 32'd6, 32'd42, -1);
    run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, -1);
    run_op("mul_min", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, -1);
    run_op("mulhu_ones", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
    run_op("mulhsu_ones", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op("mulh_ones", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, -1);
    run_op("mul_ones", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, -1);
    run_op("mulhsu_neg", 3'b010, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, -1);
    run_op("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, -1);
    run_op("mulh_max", 3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, -1);
    run_op("mulh_min1", 3'b001, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, -1);
    run_op("mulhu_carry", 3'b011, 32'h8000_0000, 32'd2, 32'h0000_0001, -1);
    run_op("disturbed", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    run_op("mul_zero", 3'b000, 32'd0, 32'd5, 32'd0, -1);
    run_op("mulh_negzero", 3'b001, 32'hFFFF_FFFF, 32'd0, 32'd0, -1);
    for (int i = 0; i < 4; i++) begin
      logic [2:0] f;
      logic [XLEN-1:0] a, b;
      f = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      run_op("random", f, a, b, ref_mul(f, a, b), -1);
    end
    for (int i = 4; i < 8; i++) begin
      bus.start_i  = 1'b1;
      bus.funct3_i = 3'(i);
      bus.rs1_i    = 32'd9;
      bus.rs2_i    = 32'd9;
      @(negedge clk);
      check("div_ignored_ready", 64'(bus.ready_o), 64'd1);
      check("div_ignored_busy", 64'(bus.busy_o), 64'd0);
    end
    bus.start_i  = 1'b1;
    bus.funct3_i = 3'b000;
    bus.rs1_i    = 32'd3;
    bus.rs2_i    = 32'd4;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 64'(bus.ready_o), 64'd1);
    check("midrst_busy", 64'(bus.busy_o), 64'd0);
    check("midrst_valid", 64'(bus.valid_o), 64'd0);
    check("midrst_result", 64'(bus.result_o), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o) pulses++;
    end
    check("midrst_no_pulse", 64'(pulses), 64'd0);
    run_op("after_rst", 3'b000, 32'd7, 32'd6, 32'd42, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
